flit_ejection_buffer: RTL and testbench
=======================================

Name: flit_ejection_buffer

Overview:
- Multi-VC ejection stage between one network receive port (flit/credit interface) and a single valid/ready flit consumer (AXI4 master/slave bridge side).
- Buffers arriving flits in per-VC FIFOs sized to the network's credit allocation.
- Arbitrates VCs round-robin at packet granularity and returns one credit per dequeued flit.

Parameters:
- FLIT_WIDTH, 72, total flit width; bit FLIT_WIDTH-1 is the valid bit.
- NUM_VCS, 2, number of virtual channels (power of two, >=2).
- VC_BITS, 1, log2(NUM_VCS).
- TAIL_BIT, 70, bit index of the tail flag inside the flit.
- VC_LSB, 64, LSB of the VC_BITS-wide VC field inside the flit.
- BUF_DEPTH, 8, flits per VC FIFO; equals the network's initial credits per VC (power of two).

Ports:
- CLK  input  1  clock
- RST_N  input  1  asynchronous active-low reset
- recv_ports_getFlit  input  FLIT_WIDTH  flit from network; valid when MSB=1
- EN_recv_ports_getFlit  output  1  sample enable to network
- recv_ports_putCredits_cr_in  output  VC_BITS+1  credit {valid, vc}
- EN_recv_ports_putCredits  output  1  credit strobe
- get_flit  output  FLIT_WIDTH  flit to consumer, bit-identical to the received flit
- get_flit_valid  output  1  get_flit holds a flit
- get_flit_ready  input  1  consumer accepts
- overflow_err  output  1  sticky: flit arrived for a full VC FIFO

Behaviour:
- Reset values (async, RST_N=0):
  - All FIFOs empty; arbiter pointer = VC0; lock cleared.
  - EN_recv_ports_getFlit=0, EN_recv_ports_putCredits=0, cr_in=0, get_flit_valid=0, get_flit=0, overflow_err=0.
- EN_recv_ports_getFlit is registered: 1 from the first clock edge after reset release, constant thereafter.
- Enqueue:
  - When EN_recv_ports_getFlit=1 and recv_ports_getFlit[FLIT_WIDTH-1]=1, the flit is written into FIFO[vc] on that edge, where vc = flit[VC_LSB+VC_BITS-1:VC_LSB].
  - At most one enqueue per cycle.
- Overflow:
  - Enqueue to a full FIFO drops the flit and sets overflow_err.
  - overflow_err stays set until reset.
  - Pointers and count are unchanged.
- Output register:
  - One-entry output register drives get_flit/get_flit_valid.
  - The flit is removed from its FIFO on the load edge.
  - The register reloads in the same cycle it is drained: valid&&ready plus an eligible VC gives back-to-back throughput of 1 flit/cycle.
  - While get_flit_valid=1 and ready=0, get_flit holds stable.
- Arbiter states:
  - IDLE: select the first non-empty VC starting at the pointer and wrapping modulo NUM_VCS. On load of a non-tail flit go to LOCKED(vc). On load of a tail flit stay IDLE and set pointer = vc+1 mod NUM_VCS.
  - LOCKED(v): load only from FIFO[v]; other VCs wait even if non-empty. On loading the tail flit of v, return to IDLE with pointer = v+1.
  - A single-flit packet (tail set on head) never locks.
- Latency: a flit arriving into an empty FIFO with an eligible arbiter and an empty or draining output register is valid on get_flit the cycle after enqueue. Enqueue edge N gives valid in cycle N+1 at earliest, because the FIFO is registered and the load occurs on edge N+1.
- Credits:
  - On each edge where a flit leaves FIFO[v] into the output register, the next cycle has EN_recv_ports_putCredits=1 and cr_in={1'b1,v}.
  - Otherwise EN=0 and cr_in=0.
  - Exactly one credit per dequeue.
- Simultaneous events: enqueue and dequeue on the same FIFO in one cycle are both honoured. A full FIFO that is dequeued in the same cycle accepts the enqueue with no overflow.
- Occupancy: per-FIFO count of width log2(BUF_DEPTH)+1; read/write pointers wrap modulo BUF_DEPTH.
- Reset mid-packet: all state, including lock and buffered flits, is discarded immediately. No credits are emitted for discarded flits.

Test Plan:
- Reset release, no traffic -> EN_recv_ports_getFlit=1 from the first edge; get_flit_valid=0; no credits for 20 cycles.
- Single-flit packet on VC1 (tail=1, data 0xA5), ready=1 -> get_flit valid one cycle after enqueue with identical 72-bit value; next cycle cr_in=2'b11, EN_putCredits=1, for exactly one cycle.
- Interleaving:
  - Stimulus: 3-flit packet on VC0 interleaved with 2-flit packet on VC1 on alternate cycles, ready=1.
  - Response: all three VC0 flits delivered contiguously, then both VC1 flits. Five credits total: 3 tagged VC0, 2 tagged VC1.
- Backpressure with saturated inputs:
  - Stimulus: ready=0, 8 flits pushed on VC0, then a 9th while the output register holds flit 1.
  - Response: 9th accepted (8 buffered + 1 in register), no overflow_err.
  - A 10th flit sets overflow_err=1 and stays set after ready=1 drains.
- Round-robin fairness with single-flit packets:
  - Stimulus: both VCs continuously non-empty, ready=1.
  - Response: output alternates VC0,VC1,VC0,... at 1 flit/cycle; credits alternate accordingly.
- Mid-packet reset:
  - Stimulus: RST_N asserted after the head of a 4-flit VC0 packet is delivered.
  - Response: outputs reset asynchronously to 0. After release, a new VC1 packet is delivered with no lock hold-over.

Source files
------------

// File: rtl/flit_ejection_buffer.sv
// Multi-VC ejection buffer: per-VC FIFOs fed from a flit/credit network port,
// drained through a one-entry output register with packet-granular round-robin.
module flit_ejection_buffer #(
   parameter int FLIT_WIDTH = 72,
   parameter int NUM_VCS    = 2,
   parameter int VC_BITS    = 1,
   parameter int TAIL_BIT   = 70,
   parameter int VC_LSB     = 64,
   parameter int BUF_DEPTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [FLIT_WIDTH-1:0] recv_ports_getFlit,
   output logic                  EN_recv_ports_getFlit,
   output logic [VC_BITS:0]      recv_ports_putCredits_cr_in,
   output logic                  EN_recv_ports_putCredits,
   output logic [FLIT_WIDTH-1:0] get_flit,
   output logic                  get_flit_valid,
   input  logic                  get_flit_ready,
   output logic                  overflow_err
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef logic [VC_BITS-1:0] vc_t;
   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

   // Flit storage and per-VC FIFO bookkeeping
   logic [FLIT_WIDTH-1:0] mem_q [NUM_VCS][BUF_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q [NUM_VCS];
   logic [PTR_W-1:0]      wr_ptr_d [NUM_VCS];
   logic [PTR_W-1:0]      rd_ptr_q [NUM_VCS];
   logic [PTR_W-1:0]      rd_ptr_d [NUM_VCS];
   logic [CNT_W-1:0]      count_q  [NUM_VCS];
   logic [CNT_W-1:0]      count_d  [NUM_VCS];
   logic [NUM_VCS-1:0]    nonempty;
   logic [NUM_VCS-1:0]    full;

   logic                  en_get_q;
   logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
   logic                  out_valid_q, out_valid_d;
   logic                  cr_en_q, cr_en_d;
   vc_t                   cr_vc_q, cr_vc_d;
   logic                  ovf_q, ovf_d;

   arb_state_e            state_q, state_d;
   vc_t                   lock_vc_q, lock_vc_d;
   vc_t                   ptr_q, ptr_d;

   logic                  enq_req, enq_ok, deq, can_load, sel_found;
   vc_t                   enq_vc, sel_vc, arb_cand;
   logic [FLIT_WIDTH-1:0] head_flit;

   assign enq_req  = en_get_q && recv_ports_getFlit[FLIT_WIDTH-1];
   assign enq_vc   = recv_ports_getFlit[VC_LSB +: VC_BITS];
   assign can_load = !out_valid_q || get_flit_ready;

   always_comb begin
      for (int v = 0; v < NUM_VCS; v++) begin
         nonempty[v] = (count_q[v] != '0);
         full[v]     = (count_q[v] == CNT_W'(BUF_DEPTH));
      end
   end

   // Scan from the highest offset down so the VC nearest the pointer wins.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first; a
      // path that leaves one unassigned would infer a latch.
      sel_found = 1'b0;
      sel_vc    = '0;
      arb_cand  = '0;
      if (state_q == ARB_LOCKED) begin
         sel_found = nonempty[lock_vc_q];
         sel_vc    = lock_vc_q;
      end else begin
         for (int i = NUM_VCS - 1; i >= 0; i--) begin
            arb_cand = ptr_q + vc_t'(i);
            if (nonempty[arb_cand]) begin
               sel_found = 1'b1;
               sel_vc    = arb_cand;
            end
         end
      end
   end

   assign deq       = can_load && sel_found;
   assign head_flit = mem_q[sel_vc][rd_ptr_q[sel_vc]];

   // A full FIFO that is being read this cycle still has room for the writer.
   assign enq_ok = enq_req && (!full[enq_vc] || (deq && (sel_vc == enq_vc)));
   assign ovf_d  = ovf_q || (enq_req && !enq_ok);

   always_comb begin
      for (int v = 0; v < NUM_VCS; v++) begin
         wr_ptr_d[v] = wr_ptr_q[v];
         rd_ptr_d[v] = rd_ptr_q[v];
         count_d[v]  = count_q[v];
         if (enq_ok && (enq_vc == vc_t'(v))) begin
            wr_ptr_d[v] = wr_ptr_q[v] + PTR_W'(1);
            count_d[v]  = count_d[v] + CNT_W'(1);
         end
         if (deq && (sel_vc == vc_t'(v))) begin
            rd_ptr_d[v] = rd_ptr_q[v] + PTR_W'(1);
            count_d[v]  = count_d[v] - CNT_W'(1);
         end
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_flit_d  = out_flit_q;
      cr_en_d     = 1'b0;
      cr_vc_d     = '0;
      state_d     = state_q;
      lock_vc_d   = lock_vc_q;
      ptr_d       = ptr_q;
      if (deq) begin
         out_valid_d = 1'b1;
         out_flit_d  = head_flit;
         cr_en_d     = 1'b1;
         cr_vc_d     = sel_vc;
         if (head_flit[TAIL_BIT]) begin
            state_d = ARB_IDLE;
            ptr_d   = sel_vc + vc_t'(1);
         end else begin
            state_d   = ARB_LOCKED;
            lock_vc_d = sel_vc;
         end
      end else if (get_flit_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // NOTE: the flit array has no reset; the occupancy counters decide what is
   // live, so clearing storage would only cost reset fan-out.
   always_ff @(posedge CLK) begin
      if (enq_ok) mem_q[enq_vc][wr_ptr_q[enq_vc]] <= recv_ports_getFlit;
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so
   // every register samples pre-edge values regardless of process order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int v = 0; v < NUM_VCS; v++) begin
            wr_ptr_q[v] <= '0;
            rd_ptr_q[v] <= '0;
            count_q[v]  <= '0;
         end
         en_get_q    <= 1'b0;
         out_flit_q  <= '0;
         out_valid_q <= 1'b0;
         cr_en_q     <= 1'b0;
         cr_vc_q     <= '0;
         ovf_q       <= 1'b0;
         state_q     <= ARB_IDLE;
         lock_vc_q   <= '0;
         ptr_q       <= '0;
      end else begin
         for (int v = 0; v < NUM_VCS; v++) begin
            wr_ptr_q[v] <= wr_ptr_d[v];
            rd_ptr_q[v] <= rd_ptr_d[v];
            count_q[v]  <= count_d[v];
         end
         en_get_q    <= 1'b1;
         out_flit_q  <= out_flit_d;
         out_valid_q <= out_valid_d;
         cr_en_q     <= cr_en_d;
         cr_vc_q     <= cr_vc_d;
         ovf_q       <= ovf_d;
         state_q     <= state_d;
         lock_vc_q   <= lock_vc_d;
         ptr_q       <= ptr_d;
      end
   end

   assign EN_recv_ports_getFlit       = en_get_q;
   assign EN_recv_ports_putCredits    = cr_en_q;
   assign recv_ports_putCredits_cr_in = {cr_en_q, cr_vc_q};
   assign get_flit                    = out_flit_q;
   assign get_flit_valid              = out_valid_q;
   assign overflow_err                = ovf_q;

endmodule

// File: tb/tb_flit_ejection_buffer.sv
// Directed bench for flit_ejection_buffer: a per-cycle vector table for the
// single-flit path plus hand-written multi-cycle sequences.
module tb_flit_ejection_buffer;

   localparam int FW = 72;
   localparam int VB = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [FW-1:0] flit_in = '0;
   logic          gready = 1'b0;
   logic          en_get, cr_en, gvalid, ovf;
   logic [VB:0]   cr;
   logic [FW-1:0] gflit;

   always #5 clk = ~clk;

   flit_ejection_buffer dut (
      .CLK                         (clk),
      .RST_N                       (rst_n),
      .recv_ports_getFlit          (flit_in),
      .EN_recv_ports_getFlit       (en_get),
      .recv_ports_putCredits_cr_in (cr),
      .EN_recv_ports_putCredits    (cr_en),
      .get_flit                    (gflit),
      .get_flit_valid              (gvalid),
      .get_flit_ready              (gready),
      .overflow_err                (ovf)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [FW-1:0] mk(input logic tail, input logic vc, input logic [31:0] data);
      logic [FW-1:0] f;
      f       = '0;
      f[FW-1] = 1'b1;
      f[70]   = tail;
      f[64]   = vc;
      f[31:0] = data;
      return f;
   endfunction

   // Monitor: accepted flits and credits, sampled on the falling edge
   logic          mon_on = 1'b0;
   logic [FW-1:0] out_q [$];
   logic [VB:0]   cr_q [$];
   int            acc_cyc [$];
   int            cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (mon_on) begin
         if (gvalid && gready) begin
            out_q.push_back(gflit);
            acc_cyc.push_back(cyc);
         end
         if (cr_en) cr_q.push_back(cr);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      mon_on  = 1'b0;
      rst_n   = 1'b0;
      flit_in = '0;
      gready  = 1'b0;
      tick();
      tick();
      out_q.delete();
      cr_q.delete();
      acc_cyc.delete();
      rst_n  = 1'b1;
      mon_on = 1'b1;
   endtask

   task automatic wait_outputs(input int n, input int budget);
      for (int c = 0; c < budget && out_q.size() < n; c++) tick();
   endtask

   typedef struct {
      logic [FW-1:0] flit;
      logic          ready;
      logic          exp_en_get;
      logic          exp_valid;
      logic [FW-1:0] exp_flit;
      logic          exp_cr_en;
      logic [VB:0]   exp_cr;
      logic          exp_ovf;
   } vec_t;

   vec_t          vt [5];
   logic [FW-1:0] f_a5;
   logic [FW-1:0] pk [10];
   logic [FW-1:0] seq [6];
   logic [FW-1:0] exp_seq [6];
   logic [VB:0]   exp_cr_seq [6];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      f_a5 = mk(1'b1, 1'b1, 32'hA5);
      //        flit  rdy en  vld flit  cr_en cr     ovf
      vt[0] = '{'0,   1, 1,  0,  '0,   0,    2'b00, 0};
      vt[1] = '{f_a5, 1, 1,  0,  '0,   0,    2'b00, 0};
      vt[2] = '{'0,   1, 1,  1,  f_a5, 1,    2'b11, 0};
      vt[3] = '{'0,   1, 1,  0,  '0,   0,    2'b00, 0};
      vt[4] = '{'0,   1, 1,  0,  '0,   0,    2'b00, 0};

      // Reset state
      tick();
      tick();
      check("rst en_get",   FW'(en_get), FW'(0));
      check("rst valid",    FW'(gvalid), FW'(0));
      check("rst flit",     gflit,       '0);
      check("rst cr_en",    FW'(cr_en),  FW'(0));
      check("rst cr_in",    FW'(cr),     FW'(0));
      check("rst overflow", FW'(ovf),    FW'(0));

      // Idle after release: enable from the first edge, no output, no credits
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         check("idle en_get", FW'(en_get), FW'(1));
         check("idle valid",  FW'(gvalid), FW'(0));
         check("idle cr_en",  FW'(cr_en),  FW'(0));
      end

      // Single-flit packet on VC1, cycle by cycle
      do_reset();
      for (int i = 0; i < 5; i++) begin
         flit_in = vt[i].flit;
         gready  = vt[i].ready;
         tick();
         check($sformatf("vec%0d en_get", i), FW'(en_get), FW'(vt[i].exp_en_get));
         check($sformatf("vec%0d valid", i),  FW'(gvalid), FW'(vt[i].exp_valid));
         if (vt[i].exp_valid) check($sformatf("vec%0d flit", i), gflit, vt[i].exp_flit);
         check($sformatf("vec%0d cr_en", i),  FW'(cr_en),  FW'(vt[i].exp_cr_en));
         check($sformatf("vec%0d cr_in", i),  FW'(cr),     FW'(vt[i].exp_cr));
         check($sformatf("vec%0d ovf", i),    FW'(ovf),    FW'(vt[i].exp_ovf));
      end

      // Interleaved packets: VC0 (3 flits) and VC1 (2 flits) on alternate cycles
      do_reset();
      tick();
      gready = 1'b1;
      seq[0] = mk(1'b0, 1'b0, 32'h100);
      seq[1] = mk(1'b0, 1'b1, 32'h200);
      seq[2] = mk(1'b0, 1'b0, 32'h101);
      seq[3] = mk(1'b1, 1'b1, 32'h201);
      seq[4] = mk(1'b1, 1'b0, 32'h102);
      exp_seq[0] = seq[0]; exp_seq[1] = seq[2]; exp_seq[2] = seq[4];
      exp_seq[3] = seq[1]; exp_seq[4] = seq[3];
      exp_cr_seq[0] = 2'b10; exp_cr_seq[1] = 2'b10; exp_cr_seq[2] = 2'b10;
      exp_cr_seq[3] = 2'b11; exp_cr_seq[4] = 2'b11;
      for (int i = 0; i < 5; i++) begin
         flit_in = seq[i];
         tick();
      end
      flit_in = '0;
      wait_outputs(5, 30);
      repeat (3) tick();
      check("ilv out count",    FW'(out_q.size()), FW'(5));
      check("ilv credit count", FW'(cr_q.size()),  FW'(5));
      for (int i = 0; i < 5; i++) begin
         if (i < out_q.size()) check($sformatf("ilv out%0d", i), out_q[i], exp_seq[i]);
         if (i < cr_q.size())  check($sformatf("ilv cr%0d", i),  FW'(cr_q[i]), FW'(exp_cr_seq[i]));
      end

      // Backpressure: 8 buffered plus 1 held, then a 10th overflows
      do_reset();
      tick();
      gready = 1'b0;
      for (int k = 0; k < 10; k++) pk[k] = mk(1'b0, 1'b0, 32'h300 + 32'(k));
      for (int k = 0; k < 8; k++) begin
         flit_in = pk[k];
         tick();
      end
      check("bp held valid", FW'(gvalid), FW'(1));
      check("bp held flit",  gflit,       pk[0]);
      check("bp ovf @8",     FW'(ovf),    FW'(0));
      flit_in = pk[8];
      tick();
      check("bp ovf @9",      FW'(ovf), FW'(0));
      check("bp held flit 9", gflit,    pk[0]);
      flit_in = pk[9];
      tick();
      flit_in = '0;
      check("bp ovf @10", FW'(ovf), FW'(1));
      gready = 1'b1;
      wait_outputs(9, 40);
      repeat (3) tick();
      check("bp out count",    FW'(out_q.size()), FW'(9));
      check("bp credit count", FW'(cr_q.size()),  FW'(9));
      check("bp ovf sticky",   FW'(ovf),          FW'(1));
      for (int k = 0; k < 9; k++) begin
         if (k < out_q.size()) check($sformatf("bp out%0d", k), out_q[k], pk[k]);
         if (k < cr_q.size())  check($sformatf("bp cr%0d", k),  FW'(cr_q[k]), FW'(2'b10));
      end

      // Round-robin over single-flit packets with both VCs backlogged
      do_reset();
      tick();
      gready = 1'b0;
      seq[0] = mk(1'b1, 1'b0, 32'h400);
      seq[1] = mk(1'b1, 1'b1, 32'h500);
      seq[2] = mk(1'b1, 1'b0, 32'h401);
      seq[3] = mk(1'b1, 1'b1, 32'h501);
      seq[4] = mk(1'b1, 1'b0, 32'h402);
      seq[5] = mk(1'b1, 1'b1, 32'h502);
      for (int i = 0; i < 6; i++) begin
         flit_in = seq[i];
         tick();
      end
      flit_in = '0;
      tick();
      gready = 1'b1;
      wait_outputs(6, 30);
      repeat (2) tick();
      check("rr out count",    FW'(out_q.size()), FW'(6));
      check("rr credit count", FW'(cr_q.size()),  FW'(6));
      for (int i = 0; i < 6; i++) begin
         if (i < out_q.size()) begin
            check($sformatf("rr out%0d", i), out_q[i], seq[i]);
            check($sformatf("rr cycle%0d", i), FW'(acc_cyc[i] - acc_cyc[0]), FW'(i));
         end
         if (i < cr_q.size()) check($sformatf("rr cr%0d", i), FW'(cr_q[i]), FW'({1'b1, 1'(i % 2)}));
      end

      // Reset in the middle of a locked VC0 packet
      do_reset();
      tick();
      gready = 1'b1;
      seq[0] = mk(1'b0, 1'b0, 32'h600);
      seq[1] = mk(1'b0, 1'b0, 32'h601);
      seq[2] = mk(1'b0, 1'b0, 32'h602);
      for (int i = 0; i < 3; i++) begin
         flit_in = seq[i];
         tick();
      end
      flit_in = '0;
      wait_outputs(1, 10);
      check("mr head count", FW'(out_q.size() >= 1), FW'(1));
      if (out_q.size() >= 1) check("mr head flit", out_q[0], seq[0]);
      @(posedge clk);
      #3;
      mon_on = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("mr async en_get", FW'(en_get), FW'(0));
      check("mr async valid",  FW'(gvalid), FW'(0));
      check("mr async flit",   gflit,       '0);
      check("mr async cr_en",  FW'(cr_en),  FW'(0));
      check("mr async cr_in",  FW'(cr),     FW'(0));
      tick();
      out_q.delete();
      cr_q.delete();
      acc_cyc.delete();
      rst_n  = 1'b1;
      mon_on = 1'b1;
      tick();
      seq[3] = mk(1'b1, 1'b1, 32'h700);
      flit_in = seq[3];
      tick();
      flit_in = '0;
      wait_outputs(1, 10);
      repeat (3) tick();
      check("mr new count",    FW'(out_q.size()), FW'(1));
      if (out_q.size() >= 1) check("mr new flit", out_q[0], seq[3]);
      check("mr credit count", FW'(cr_q.size()),  FW'(1));
      if (cr_q.size() >= 1) check("mr credit vc", FW'(cr_q[0]), FW'(2'b11));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
